// File: rtl/dpram_byte_reader.sv
// dpram_byte_reader: 32x16 word-write RAM streamed back out as bytes (low byte first) over valid/ready.
module dpram_byte_reader #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [15:0]   wd,
  input  logic          start,
  input  logic [AW:0]   saddr,
  input  logic [AW+1:0] count,
  output logic          busy,
  output logic [7:0]    dout,
  output logic          dvalid,
  input  logic          dready,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FIN} state_t;
  state_t        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d, ptr_inc;
  logic [AW+1:0] rem_q, rem_d;
  logic [15:0]   word_q, word_d, rd_q;
  logic [15:0]   ram [2**AW];
  // Read-before-write falls out of the non-blocking update; the read port tracks ptr every cycle.
  always_ff @(posedge clk) begin
    if (we) ram[wa] <= wd;
    rd_q <= ram[ptr_q[AW:1]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
    end
  end
  assign ptr_inc = ptr_q + 1'b1;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (count != '0) begin
          ptr_d   = saddr;
          rem_d   = count;
          state_d = FETCH;
        end else state_d = FIN;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        word_d  = rd_q;
        state_d = SEND;
      end
      SEND: if (dready) begin
        ptr_d   = ptr_inc;
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == 1 ? FIN : ptr_inc[0] ? SEND : FETCH;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy   = state_q == FETCH || state_q == LOAD || state_q == SEND;
  assign dvalid = state_q == SEND;
  assign done   = state_q == FIN;
  assign dout   = ptr_q[0] ? word_q[15:8] : word_q[7:0];
endmodule
